// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// One byte per grant; the next grant waits for the UART busy flag to complete a full frame.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int N            = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*N-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       uart_write_en,
  output logic [N-1:0]               uart_tx_in,
  input  logic                       uart_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       err_timeout,
  input  logic                       err_clr,
  output logic [1:0]                 fsm_state
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [GW-1:0] LAST_ID  = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  // Handshake: req[i] is held with stable data until a one-cycle ack[i];
  // the UART gets one write_en pulse per byte and reports the frame on uart_busy.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [GW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [GW-1:0]   win_id;
  logic            win_valid;
  logic [GW-1:0]   next_ptr;

  assign fsm_state = state;

  function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[GW-1:0];
  endfunction

  // Descending scan so the lowest offset from ptr is the final (winning) assignment.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[rr_index(ptr, k)]) begin
        win_valid = 1'b1;
        win_id    = rr_index(ptr, k);
      end
    end
  end

  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      ack           <= '0;
      uart_write_en <= 1'b0;
      uart_tx_in    <= '0;
      grant_id      <= '0;
      active        <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      ack           <= '0;
      uart_write_en <= 1'b0;
      // A timeout set later in this block overrides the clear.
      if (err_clr) err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid && !uart_busy) begin
            ack           <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
            uart_write_en <= 1'b1;
            uart_tx_in    <= req_data[win_id*N +: N];
            grant_id      <= win_id;
            active        <= 1'b1;
            cnt           <= '0;
            state         <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (uart_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            err_timeout <= 1'b1;
            active      <= 1'b0;
            ptr         <= next_ptr;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!uart_busy) begin
            active <= 1'b0;
            ptr    <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
